axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- AXI4 responder (slave) for the processor-side AXI master; owns the match/action table memory that the processors read and write over AXI.
- Single-ported word SRAM of DEPTH x 32 bit behind one read FSM and one write FSM sharing the array.
- INCR and FIXED bursts of 1-256 beats, 32-bit beats, 1-bit IDs.

Parameters:
- DEPTH, 4096, number of 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- axi_awid/awaddr/awlen/awsize/awburst  input  1/32/8/3/2  write address
- axi_awlock/awcache/awprot/awqos/arlock/arcache/arprot/arqos  input  1/4/3/4 each  accepted, ignored
- axi_awvalid  input  1; axi_awready  output  1
- axi_wdata/wstrb/wlast/wvalid  input  32/4/1/1; axi_wready  output  1
- axi_bid/bresp/bvalid  output  1/2/1; axi_bready  input  1
- axi_arid/araddr/arlen/arsize/arburst/arvalid  input  1/32/8/3/2/1; axi_arready  output  1
- axi_rid/rdata/rresp/rlast/rvalid  output  1/32/2/1/1; axi_rready  input  1

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; wr_prio=1; memory contents retained.
- FSM states: IDLE, WR_DATA, WR_RESP, RD_FETCH, RD_DATA.
- IDLE ready outputs (combinational):
  - awready = IDLE & awvalid & (!arvalid | wr_prio)
  - arready = IDLE & arvalid & (!awvalid | !wr_prio)
  - AW accepted: latch id/addr/len/burst, err=OKAY, go WR_DATA, wr_prio=0.
  - AR accepted: latch likewise, go RD_FETCH, wr_prio=1.
- Address: word index = (addr - BASE_ADDR) >> 2; addr[1:0] ignored (aligned down).
  - INCR: index += 1 per beat. FIXED: index is held.
  - Index >= DEPTH, or addr < BASE_ADDR: that beat has no memory effect and the response is DECERR.
- Unsupported size/burst: size != 2 or burst in {WRAP, reserved} gives SLVERR for the whole burst, with no writes and rdata 0.
- WR_DATA:
  - wready=1; each wvalid beat writes the enabled byte lanes of wstrb in the same cycle.
  - The burst ends at beat len+1; then go WR_RESP.
  - wlast at the wrong beat sets SLVERR but does not shorten the burst.
- WR_RESP: bvalid=1, bid=latched id, bresp = worst error (DECERR > SLVERR > OKAY); hold until bready, then IDLE.
- RD_FETCH: issue synchronous read (1-cycle latency), go RD_DATA.
- RD_DATA:
  - rvalid=1; rdata/rresp/rid held stable until rready.
  - rlast=1 on beat len+1.
  - On handshake: next beat goes to RD_FETCH; last beat goes to IDLE.
  - Throughput is one beat per 2 cycles.
- Read and write never overlap; the memory port is owned by the active FSM.
- Reset mid-burst: the burst is abandoned and no response is sent; completed writes persist.

Optional Feature:
- AXI_SRAM_SLAVE_STATS_EN, when defined, adds ports:
  - stat_wr_beats output 32: count of write beats handshaken.
  - stat_rd_beats output 32: count of read beats handshaken.
  - stat_err_resp output 16: count of non-OKAY B or R handshakes.
  - All three reset to 0 and wrap silently.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package axi_pkg: AXI_RESP_OKAY/SLVERR/DECERR, AXI_BURST_FIXED/INCR/WRAP, AXI_SIZE_4B, and an enum type for the slave FSM state.
- One sub-module: sram_sp_bytewe, a single-port RAM with byte write enables and 1-cycle read (DEPTH, 32 bit).

Test Plan:
- Single write then read: AW addr=0x10 len=0 INCR, W data=0xDEADBEEF strb=F -> bresp=0. AR addr=0x10 len=0 -> rdata=0xDEADBEEF, rresp=0, rlast=1.
- INCR burst 4 beats at 0x100 (data 1..4), then read len=3 -> rdata 1,2,3,4, rlast only on beat 4. Insert rready low for 3 cycles on beat 2 -> rdata held.
- Byte strobes and FIXED burst:
  - Write 0x11223344 (strb F), then 0xAABBCCDD with strb=4'b0101 -> read 0x11BB33DD.
  - FIXED len=2 write at 0x20 with data 5,6,7 -> read 0x20 gives 7.
- Errors:
  - Write to BASE_ADDR+DEPTH*4 -> bresp=DECERR, memory unchanged.
  - awsize=1 -> SLVERR.
  - WRAP read -> rresp=SLVERR on all beats, rdata=0.
  - wlast on beat 2 of len=3 -> SLVERR, 4 beats still accepted.
- Arbitration: awvalid and arvalid asserted together from reset -> write accepted first. Then both again -> read accepted; alternation continues.
- Reset asserted during RD_DATA -> rvalid=0 immediately. A new AR after release is served normally.

Source files
------------

// File: rtl/axi_pkg.sv
// AXI4 encodings and slave FSM state type used by axi_sram_slave and friends.
package axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [2:0] AXI_SIZE_4B = 3'd2;

    // idle | write beats | write response | read array | read beat offered
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_WR_RESP,
        ST_RD_FETCH,
        ST_RD_DATA
    } slave_state_e;

    // Encodings are ordered by severity, so the worst response is the larger code.
    function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic burst_supported(input logic [2:0] size, input logic [1:0] burst);
        return (size == AXI_SIZE_4B) && (burst == AXI_BURST_FIXED || burst == AXI_BURST_INCR);
    endfunction

endpackage

// File: rtl/sram_sp_bytewe.sv
// Single-port word RAM with per-byte write enables and one-cycle registered read.
module sram_sp_bytewe #(
    parameter int DEPTH = 4096,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Read data only changes on a read access, so it holds while the reader stalls.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
            if (we == 4'b0000) rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 slave in front of a DEPTH x 32 SRAM; one read or write burst at a time.
// Optional beat/error counters are built when AXI_SRAM_SLAVE_STATS_EN is defined.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int          DEPTH     = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        axi_awid,
    input  logic [31:0] axi_awaddr,
    input  logic [7:0]  axi_awlen,
    input  logic [2:0]  axi_awsize,
    input  logic [1:0]  axi_awburst,
    input  logic        axi_awlock,
    input  logic [3:0]  axi_awcache,
    input  logic [2:0]  axi_awprot,
    input  logic [3:0]  axi_awqos,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    input  logic        axi_wlast,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    output logic        axi_bid,
    output logic [1:0]  axi_bresp,
    output logic        axi_bvalid,
    input  logic        axi_bready,
    input  logic        axi_arid,
    input  logic [31:0] axi_araddr,
    input  logic [7:0]  axi_arlen,
    input  logic [2:0]  axi_arsize,
    input  logic [1:0]  axi_arburst,
    input  logic        axi_arlock,
    input  logic [3:0]  axi_arcache,
    input  logic [2:0]  axi_arprot,
    input  logic [3:0]  axi_arqos,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    output logic        axi_rid,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        axi_rlast,
    output logic        axi_rvalid,
    input  logic        axi_rready
`ifdef AXI_SRAM_SLAVE_STATS_EN
    ,
    output logic [31:0] stat_wr_beats,
    output logic [31:0] stat_rd_beats,
    output logic [15:0] stat_err_resp
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    slave_state_e state, state_nxt;

    logic        wr_prio;
    logic        lat_id;
    logic [30:0] idx;
    logic        below;
    logic [7:0]  len;
    logic [7:0]  cnt;
    logic [1:0]  burst;
    logic        bad;
    logic [1:0]  err;

    logic [31:0] aw_off, ar_off;
    logic        oor, mem_ok, beat_last;
    logic [1:0]  beat_resp, w_resp;
    logic        aw_hs, ar_hs, w_hs, b_hs, r_hs;

    logic          ram_en;
    logic [3:0]    ram_we;
    logic [31:0]   ram_q;

    logic unused_inputs;

    assign aw_off = axi_awaddr - BASE_ADDR;
    assign ar_off = axi_araddr - BASE_ADDR;

    assign oor       = below || (idx >= 31'(DEPTH));
    assign mem_ok    = !oor && !bad;
    assign beat_last = (cnt == len);
    assign beat_resp = resp_worst(bad ? AXI_RESP_SLVERR : AXI_RESP_OKAY,
                                  oor ? AXI_RESP_DECERR : AXI_RESP_OKAY);
    assign w_resp    = resp_worst(beat_resp,
                                  (axi_wlast != beat_last) ? AXI_RESP_SLVERR : AXI_RESP_OKAY);

    assign aw_hs = axi_awvalid && axi_awready;
    assign ar_hs = axi_arvalid && axi_arready;
    assign w_hs  = axi_wvalid  && axi_wready;
    assign b_hs  = axi_bvalid  && axi_bready;
    assign r_hs  = axi_rvalid  && axi_rready;

    assign unused_inputs = ^{aw_off[1:0], ar_off[1:0], axi_awlock, axi_awcache, axi_awprot,
                             axi_awqos, axi_arlock, axi_arcache, axi_arprot, axi_arqos};

    sram_sp_bytewe #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (idx[AW-1:0]),
        .wdata (axi_wdata),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Ready is gated by rst so every output reads 0 while reset is held.
    always_comb begin
        state_nxt   = state;
        axi_awready = 1'b0;
        axi_arready = 1'b0;
        axi_wready  = 1'b0;
        axi_bvalid  = 1'b0;
        axi_bid     = 1'b0;
        axi_bresp   = AXI_RESP_OKAY;
        axi_rvalid  = 1'b0;
        axi_rid     = 1'b0;
        axi_rdata   = 32'h0;
        axi_rresp   = AXI_RESP_OKAY;
        axi_rlast   = 1'b0;
        ram_en      = 1'b0;
        ram_we      = 4'b0000;
        case (state)
            ST_IDLE: begin
                axi_awready = rst && axi_awvalid && (!axi_arvalid || wr_prio);
                axi_arready = rst && axi_arvalid && (!axi_awvalid || !wr_prio);
                if (axi_awready)      state_nxt = ST_WR_DATA;
                else if (axi_arready) state_nxt = ST_RD_FETCH;
            end
            ST_WR_DATA: begin
                axi_wready = 1'b1;
                if (axi_wvalid) begin
                    ram_en = mem_ok;
                    ram_we = mem_ok ? axi_wstrb : 4'b0000;
                    if (beat_last) state_nxt = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                axi_bvalid = 1'b1;
                axi_bid    = lat_id;
                axi_bresp  = err;
                if (axi_bready) state_nxt = ST_IDLE;
            end
            ST_RD_FETCH: begin
                ram_en    = mem_ok;
                state_nxt = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                axi_rvalid = 1'b1;
                axi_rid    = lat_id;
                axi_rdata  = mem_ok ? ram_q : 32'h0;
                axi_rresp  = beat_resp;
                axi_rlast  = beat_last;
                if (axi_rready) state_nxt = beat_last ? ST_IDLE : ST_RD_FETCH;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_prio <= 1'b1;
            lat_id  <= 1'b0;
            idx     <= '0;
            below   <= 1'b0;
            len     <= 8'd0;
            cnt     <= 8'd0;
            burst   <= AXI_BURST_INCR;
            bad     <= 1'b0;
            err     <= AXI_RESP_OKAY;
        end else begin
            if (aw_hs) begin
                lat_id  <= axi_awid;
                idx     <= {1'b0, aw_off[31:2]};
                below   <= (axi_awaddr < BASE_ADDR);
                len     <= axi_awlen;
                cnt     <= 8'd0;
                burst   <= axi_awburst;
                bad     <= !burst_supported(axi_awsize, axi_awburst);
                err     <= AXI_RESP_OKAY;
                wr_prio <= 1'b0;
            end else if (ar_hs) begin
                lat_id  <= axi_arid;
                idx     <= {1'b0, ar_off[31:2]};
                below   <= (axi_araddr < BASE_ADDR);
                len     <= axi_arlen;
                cnt     <= 8'd0;
                burst   <= axi_arburst;
                bad     <= !burst_supported(axi_arsize, axi_arburst);
                err     <= AXI_RESP_OKAY;
                wr_prio <= 1'b1;
            end
            if (w_hs) err <= resp_worst(err, w_resp);
            if (w_hs || r_hs) begin
                cnt <= cnt + 8'd1;
                if (burst == AXI_BURST_INCR) idx <= idx + 31'd1;
            end
        end
    end

`ifdef AXI_SRAM_SLAVE_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_wr_beats <= 32'd0;
            stat_rd_beats <= 32'd0;
            stat_err_resp <= 16'd0;
        end else begin
            if (w_hs) stat_wr_beats <= stat_wr_beats + 32'd1;
            if (r_hs) stat_rd_beats <= stat_rd_beats + 32'd1;
            if ((b_hs && axi_bresp != AXI_RESP_OKAY) || (r_hs && axi_rresp != AXI_RESP_OKAY))
                stat_err_resp <= stat_err_resp + 16'd1;
        end
    end
`else
    logic unused_hs;
    assign unused_hs = b_hs;
`endif

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave with hand-computed expectations.
module tb_axi_sram_slave;
    import axi_pkg::*;

    localparam int LIM = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        axi_awid = 1'b0;
    logic [31:0] axi_awaddr = '0;
    logic [7:0]  axi_awlen = '0;
    logic [2:0]  axi_awsize = 3'd2;
    logic [1:0]  axi_awburst = 2'b01;
    logic        axi_awvalid = 1'b0;
    logic        axi_awready;
    logic [31:0] axi_wdata = '0;
    logic [3:0]  axi_wstrb = '0;
    logic        axi_wlast = 1'b0;
    logic        axi_wvalid = 1'b0;
    logic        axi_wready;
    logic        axi_bid;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready = 1'b0;
    logic        axi_arid = 1'b0;
    logic [31:0] axi_araddr = '0;
    logic [7:0]  axi_arlen = '0;
    logic [2:0]  axi_arsize = 3'd2;
    logic [1:0]  axi_arburst = 2'b01;
    logic        axi_arvalid = 1'b0;
    logic        axi_arready;
    logic        axi_rid;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rlast;
    logic        axi_rvalid;
    logic        axi_rready = 1'b0;
`ifdef AXI_SRAM_SLAVE_STATS_EN
    logic [31:0] stat_wr_beats, stat_rd_beats;
    logic [15:0] stat_err_resp;
`endif

    axi_sram_slave dut (
        .clk(clk), .rst(rst),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awlock(1'b0),
        .axi_awcache(4'h0), .axi_awprot(3'h0), .axi_awqos(4'h0),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arlock(1'b0),
        .axi_arcache(4'h0), .axi_arprot(3'h0), .axi_arqos(4'h0),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
`ifdef AXI_SRAM_SLAVE_STATS_EN
        ,
        .stat_wr_beats(stat_wr_beats), .stat_rd_beats(stat_rd_beats), .stat_err_resp(stat_err_resp)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    logic [31:0] wbuf [256];
    logic [3:0]  sbuf [256];
    logic [31:0] rbuf [256];
    logic [1:0]  rrbuf [256];
    logic        rlbuf [256];
    logic        rid_seen;
    int          w_beats;

    task automatic aw_issue(input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic id);
        int n;
        axi_awaddr = addr; axi_awlen = len; axi_awsize = size; axi_awburst = burst; axi_awid = id;
        axi_awvalid = 1'b1;
        #1;
        n = 0;
        while (!axi_awready && n < LIM) begin @(posedge clk); #1; n++; end
        chk("aw_timeout", 32'(n >= LIM), 0);
        @(posedge clk); #1;
        axi_awvalid = 1'b0;
    endtask

    task automatic ar_issue(input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic id);
        int n;
        axi_araddr = addr; axi_arlen = len; axi_arsize = size; axi_arburst = burst; axi_arid = id;
        axi_arvalid = 1'b1;
        #1;
        n = 0;
        while (!axi_arready && n < LIM) begin @(posedge clk); #1; n++; end
        chk("ar_timeout", 32'(n >= LIM), 0);
        @(posedge clk); #1;
        axi_arvalid = 1'b0;
    endtask

    // bad_last < 0 puts wlast on the final beat; otherwise on beat index bad_last.
    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic id, input int bad_last,
                            output logic [1:0] resp, output logic bid);
        int n;
        aw_issue(addr, len, size, burst, id);
        w_beats = 0;
        for (int i = 0; i <= int'(len); i++) begin
            axi_wdata  = wbuf[i];
            axi_wstrb  = sbuf[i];
            axi_wlast  = (bad_last < 0) ? (i == int'(len)) : (i == bad_last);
            axi_wvalid = 1'b1;
            #1;
            n = 0;
            while (!axi_wready && n < LIM) begin @(posedge clk); #1; n++; end
            chk("w_timeout", 32'(n >= LIM), 0);
            @(posedge clk); #1;
            w_beats++;
        end
        axi_wvalid = 1'b0;
        axi_wlast  = 1'b0;
        axi_bready = 1'b1;
        #1;
        n = 0;
        while (!axi_bvalid && n < LIM) begin @(posedge clk); #1; n++; end
        chk("b_timeout", 32'(n >= LIM), 0);
        resp = axi_bresp;
        bid  = axi_bid;
        @(posedge clk); #1;
        axi_bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic id,
                           input int stall_beat, input logic [31:0] hold_exp);
        int n;
        ar_issue(addr, len, size, burst, id);
        for (int i = 0; i <= int'(len); i++) begin
            n = 0;
            while (!axi_rvalid && n < LIM) begin @(posedge clk); #1; n++; end
            chk("r_timeout", 32'(n >= LIM), 0);
            if (i == stall_beat) begin
                repeat (3) begin
                    @(posedge clk); #1;
                    chk("rd_hold_valid", 32'(axi_rvalid), 1);
                    chk("rd_hold_data", axi_rdata, hold_exp);
                end
            end
            axi_rready = 1'b1;
            #1;
            rbuf[i]  = axi_rdata;
            rrbuf[i] = axi_rresp;
            rlbuf[i] = axi_rlast;
            rid_seen = axi_rid;
            @(posedge clk); #1;
            axi_rready = 1'b0;
        end
    endtask

    logic [1:0] resp;
    logic       bid;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Both requests pending while reset is held: every output stays low.
        axi_awvalid = 1'b1;
        axi_arvalid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", 32'(axi_awready), 0);
        chk("rst_arready", 32'(axi_arready), 0);
        chk("rst_bvalid",  32'(axi_bvalid), 0);
        chk("rst_rvalid",  32'(axi_rvalid), 0);
        chk("rst_wready",  32'(axi_wready), 0);
        rst = 1'b1;
        #1;
        chk("arb1_awready", 32'(axi_awready), 1);
        chk("arb1_arready", 32'(axi_arready), 0);
        axi_arvalid = 1'b0;

        wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
        do_write(32'h10, 8'd0, 3'd2, AXI_BURST_INCR, 1'b1, -1, resp, bid);
        chk("single_bresp", 32'(resp), 0);
        chk("single_bid", 32'(bid), 1);

        axi_awvalid = 1'b1;
        axi_arvalid = 1'b1;
        #1;
        chk("arb2_arready", 32'(axi_arready), 1);
        chk("arb2_awready", 32'(axi_awready), 0);
        axi_awvalid = 1'b0;
        do_read(32'h10, 8'd0, 3'd2, AXI_BURST_INCR, 1'b1, -1, 32'h0);
        chk("single_rdata", rbuf[0], 32'hDEADBEEF);
        chk("single_rresp", 32'(rrbuf[0]), 0);
        chk("single_rlast", 32'(rlbuf[0]), 1);
        chk("single_rid", 32'(rid_seen), 1);

        axi_awvalid = 1'b1;
        axi_arvalid = 1'b1;
        #1;
        chk("arb3_awready", 32'(axi_awready), 1);
        chk("arb3_arready", 32'(axi_arready), 0);
        axi_arvalid = 1'b0;

        // INCR burst of four beats, read back with a three-cycle stall on beat 2.
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
        do_write(32'h100, 8'd3, 3'd2, AXI_BURST_INCR, 1'b0, -1, resp, bid);
        chk("incr_bresp", 32'(resp), 0);
        do_read(32'h100, 8'd3, 3'd2, AXI_BURST_INCR, 1'b0, 1, 32'h2);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("incr_rdata%0d", i), rbuf[i], 32'(i + 1));
            chk($sformatf("incr_rlast%0d", i), 32'(rlbuf[i]), 32'(i == 3));
        end

        // Byte strobes: lanes 0 and 2 of the second write land.
        wbuf[0] = 32'h11223344; sbuf[0] = 4'hF;
        do_write(32'h200, 8'd0, 3'd2, AXI_BURST_INCR, 1'b0, -1, resp, bid);
        wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'b0101;
        do_write(32'h200, 8'd0, 3'd2, AXI_BURST_INCR, 1'b0, -1, resp, bid);
        do_read(32'h200, 8'd0, 3'd2, AXI_BURST_INCR, 1'b0, -1, 32'h0);
        chk("strb_rdata", rbuf[0], 32'h11BB33DD);

        // FIXED burst: every beat hits the same word, the last one wins.
        wbuf[0] = 32'd5; wbuf[1] = 32'd6; wbuf[2] = 32'd7;
        sbuf[0] = 4'hF;  sbuf[1] = 4'hF;  sbuf[2] = 4'hF;
        do_write(32'h20, 8'd2, 3'd2, AXI_BURST_FIXED, 1'b0, -1, resp, bid);
        chk("fixed_bresp", 32'(resp), 0);
        do_read(32'h20, 8'd0, 3'd2, AXI_BURST_INCR, 1'b0, -1, 32'h0);
        chk("fixed_rdata", rbuf[0], 32'd7);

        // Out of range write must not alias onto word 0.
        wbuf[0] = 32'hCAFE0000; sbuf[0] = 4'hF;
        do_write(32'h0, 8'd0, 3'd2, AXI_BURST_INCR, 1'b0, -1, resp, bid);
        wbuf[0] = 32'h12345678;
        do_write(32'h4000, 8'd0, 3'd2, AXI_BURST_INCR, 1'b0, -1, resp, bid);
        chk("oor_bresp", 32'(resp), 32'(AXI_RESP_DECERR));
        do_read(32'h0, 8'd0, 3'd2, AXI_BURST_INCR, 1'b0, -1, 32'h0);
        chk("oor_word0", rbuf[0], 32'hCAFE0000);
        do_read(32'h4000, 8'd0, 3'd2, AXI_BURST_INCR, 1'b0, -1, 32'h0);
        chk("oor_rresp", 32'(rrbuf[0]), 32'(AXI_RESP_DECERR));
        chk("oor_rdata", rbuf[0], 32'h0);

        // Narrow size: SLVERR and no write.
        wbuf[0] = 32'h77; sbuf[0] = 4'hF;
        do_write(32'h300, 8'd0, 3'd2, AXI_BURST_INCR, 1'b0, -1, resp, bid);
        wbuf[0] = 32'h55;
        do_write(32'h300, 8'd0, 3'd1, AXI_BURST_INCR, 1'b0, -1, resp, bid);
        chk("size_bresp", 32'(resp), 32'(AXI_RESP_SLVERR));
        do_read(32'h300, 8'd0, 3'd2, AXI_BURST_INCR, 1'b0, -1, 32'h0);
        chk("size_nowrite", rbuf[0], 32'h77);

        // WRAP read: every beat SLVERR with zero data.
        do_read(32'h100, 8'd1, 3'd2, AXI_BURST_WRAP, 1'b0, -1, 32'h0);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("wrap_rresp%0d", i), 32'(rrbuf[i]), 32'(AXI_RESP_SLVERR));
            chk($sformatf("wrap_rdata%0d", i), rbuf[i], 32'h0);
        end
        chk("wrap_rlast", 32'(rlbuf[1]), 1);

        // Early wlast: SLVERR, but all four beats still accepted.
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(9 + i); sbuf[i] = 4'hF; end
        do_write(32'h400, 8'd3, 3'd2, AXI_BURST_INCR, 1'b0, 1, resp, bid);
        chk("wlast_bresp", 32'(resp), 32'(AXI_RESP_SLVERR));
        chk("wlast_beats", 32'(w_beats), 4);

        // Reset while a read beat is offered, then a clean read.
        begin
            int n;
            ar_issue(32'h100, 8'd3, 3'd2, AXI_BURST_INCR, 1'b0);
            n = 0;
            while (!axi_rvalid && n < LIM) begin @(posedge clk); #1; n++; end
            chk("rstmid_wait", 32'(n >= LIM), 0);
            rst = 1'b0;
            #1;
            chk("rstmid_rvalid", 32'(axi_rvalid), 0);
            @(posedge clk); #1;
            rst = 1'b1;
        end
        do_read(32'h104, 8'd0, 3'd2, AXI_BURST_INCR, 1'b0, -1, 32'h0);
        chk("rstmid_rdata", rbuf[0], 32'd2);
        chk("rstmid_rresp", 32'(rrbuf[0]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
